instr_fetch_unit: RTL

Sequential instruction fetch front end that produces the instruction stream consumed by the control unit's main and ALU decoders. Holds the PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, and registers the returned word. It presents the opcode, funct3, funct7 and register fields with a valid flag, and redirects on taken branches or jumps.

---
 rtl/instr_fetch_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch front end.
// Holds the PC, issues one word request at a time over a req/gnt/rvalid
// handshake, registers the returned word and exposes its decode fields.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into FAULT and drives fetch_fault; otherwise the target is word-aligned).
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [6:0]  op,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        fetch_fault
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FAULT = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3
   } state_t;
`endif

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_valid;
   logic        r_req;
   logic        r_drop;   // the outstanding response belongs to a stale fetch
   logic [31:0] w_redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic        r_fault;
   logic        w_redir_bad;

   // Misaligned targets trap; aligned ones are used as given.
   assign w_redir_tgt = redirect_pc;
   assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign fetch_fault = r_fault;
`else
   // Without the trap the low two bits of the target are simply ignored.
   assign w_redir_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

   // Fetch FSM: PC, request, captured instruction and drop tracking.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_RST;
         r_pc    <= RESET_PC;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
         r_req   <= 1'b0;
         r_drop  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_fault <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_RST: begin
               r_state <= ST_REQ;
               r_req   <= 1'b1;
            end
            ST_REQ: begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (w_redir_bad) begin
                  r_state <= ST_FAULT;
                  r_req   <= 1'b0;
                  r_fault <= 1'b1;
                  r_pc    <= w_redir_tgt;
                  r_drop  <= imem_gnt;
               end else
`endif
               if (imem_gnt) begin
                  // Granted: a redirect in the same cycle orphans this response.
                  r_state <= ST_WAIT;
                  r_req   <= 1'b0;
                  if (redirect_valid) begin
                     r_pc   <= w_redir_tgt;
                     r_drop <= 1'b1;
                  end
               end else if (redirect_valid) begin
                  // Ungranted request simply retargets.
                  r_pc <= w_redir_tgt;
               end
            end
            ST_WAIT: begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (w_redir_bad) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                  r_pc    <= w_redir_tgt;
                  r_drop  <= !imem_rvalid;
               end else
`endif
               if (redirect_valid) begin
                  r_pc <= w_redir_tgt;
                  if (imem_rvalid) begin
                     r_state <= ST_REQ;
                     r_req   <= 1'b1;
                     r_drop  <= 1'b0;
                  end else begin
                     r_drop  <= 1'b1;
                  end
               end else if (imem_rvalid) begin
                  if (r_drop) begin
                     r_state <= ST_REQ;
                     r_req   <= 1'b1;
                     r_drop  <= 1'b0;
                  end else begin
                     r_state <= ST_HOLD;
                     r_instr <= imem_rdata;
                     r_valid <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
`ifdef FETCH_MISALIGN_TRAP_EN
               if (w_redir_bad) begin
                  r_state <= ST_FAULT;
                  r_valid <= 1'b0;
                  r_fault <= 1'b1;
                  r_pc    <= w_redir_tgt;
               end else
`endif
               if (redirect_valid) begin
                  r_state <= ST_REQ;
                  r_pc    <= w_redir_tgt;
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
               end else if (!stall) begin
                  r_state <= ST_REQ;
                  r_pc    <= r_pc + 32'd4;
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_FAULT: begin
               // Parked until reset; only swallow a stale response.
               if (imem_rvalid && r_drop) begin
                  r_drop <= 1'b0;
               end
            end
`endif
            default: begin
               r_state <= ST_RST;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
               r_drop  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_valid;

   assign op    = r_instr[6:0];
   assign rd    = r_instr[11:7];
   assign func3 = r_instr[14:12];
   assign rs1   = r_instr[19:15];
   assign rs2   = r_instr[24:20];
   assign func7 = r_instr[31:25];

endmodule
